// File: rtl/relax_osc_ctrl.sv
// Relaxation oscillator calibration: settle, count osc edges over a gate window, step trim toward a target window.
// Run length = MAX_ITER x (SETTLE_CYCLES + GATE_CYCLES + 1) + 1 clk worst case; start is ignored while busy.
module relax_osc_ctrl #(
    parameter int TRIM_W        = 4,
    parameter int TRIM_INIT     = 8,
    parameter int CNT_W         = 8,
    parameter int GATE_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_ITER      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              osc_in,
    input  logic [CNT_W-1:0]  target_lo,
    input  logic [CNT_W-1:0]  target_hi,
    output logic              osc_en,
    output logic [TRIM_W-1:0] trim,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              locked
);

    localparam int PH_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int IT_W   = $clog2(MAX_ITER + 1);

    localparam logic [TRIM_W-1:0] TRIM_RST    = TRIM_W'(TRIM_INIT);
    localparam logic [TRIM_W-1:0] TRIM_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]   GATE_LAST   = PH_W'(GATE_CYCLES - 1);
    localparam logic [IT_W-1:0]   ITER_LAST   = IT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        ADJUST  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q, sync_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic [TRIM_W-1:0] trim_q, trim_d;
    logic              osc_en_q, osc_en_d;
    logic              locked_q, locked_d;

    logic              edge_pls;
    logic [CNT_W-1:0]  ecnt_inc;
    logic              in_win, step_up, step_dn, at_limit, adj_end;

    // sync_q[1] is the second synchroniser stage, sync_q[2] its one-cycle delayed copy
    assign edge_pls = sync_q[1] & ~sync_q[2];
    assign ecnt_inc = (edge_pls && (ecnt_q != CNT_MAX)) ? ecnt_q + CNT_W'(1) : ecnt_q;

    // Window test has priority, so an empty window (lo > hi) still steps trim up first
    assign in_win   = (count_q >= target_lo) && (count_q <= target_hi);
    assign step_up  = !in_win && (count_q < target_lo);
    assign step_dn  = !in_win && !step_up;
    assign at_limit = (step_up && (trim_q == TRIM_MAX)) || (step_dn && (trim_q == '0));
    assign adj_end  = in_win || at_limit || (iter_q == ITER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            ph_q     <= '0;
            ecnt_q   <= '0;
            count_q  <= '0;
            iter_q   <= '0;
            trim_q   <= TRIM_RST;
            osc_en_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            ph_q     <= ph_d;
            ecnt_q   <= ecnt_d;
            count_q  <= count_d;
            iter_q   <= iter_d;
            trim_q   <= trim_d;
            osc_en_q <= osc_en_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (ph_q == SETTLE_LAST) state_d = MEASURE;
            MEASURE: if (ph_q == GATE_LAST) state_d = ADJUST;
            ADJUST:  state_d = adj_end ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_d   = {sync_q[1:0], osc_in};
        ph_d     = ph_q;
        ecnt_d   = ecnt_q;
        count_d  = count_q;
        iter_d   = iter_q;
        trim_d   = trim_q;
        osc_en_d = osc_en_q;
        locked_d = locked_q;
        case (state_q)
            IDLE: begin
                ph_d = '0;
                if (start) begin
                    trim_d   = TRIM_RST;
                    locked_d = 1'b0;
                    iter_d   = '0;
                    osc_en_d = 1'b1;
                end
            end
            SETTLE: begin
                ecnt_d = '0;
                ph_d   = (ph_q == SETTLE_LAST) ? '0 : ph_q + PH_W'(1);
            end
            MEASURE: begin
                ecnt_d = ecnt_inc;
                if (ph_q == GATE_LAST) begin
                    ph_d    = '0;
                    count_d = ecnt_inc;
                    iter_d  = iter_q + IT_W'(1);
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ADJUST: begin
                if (in_win)
                    locked_d = 1'b1;
                if (step_up && !at_limit)
                    trim_d = trim_q + TRIM_W'(1);
                if (step_dn && !at_limit)
                    trim_d = trim_q - TRIM_W'(1);
                // A failed run drops the enable so it is already low during DONE
                if (adj_end && !in_win)
                    osc_en_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign osc_en = osc_en_q;
    assign trim   = trim_q;
    assign count  = count_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_relax_osc_ctrl.sv
// Directed bench for relax_osc_ctrl: main instance plus trim-saturation and count-saturation variants.
module tb_relax_osc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_x = 1'b0;
    logic       osc_in = 1'b0;
    logic       osc_p8 = 1'b0;
    logic       osc_p2 = 1'b0;
    logic [7:0] target_lo = 8'd3;
    logic [7:0] target_hi = 8'd5;

    logic       osc_en, busy, done, locked;
    logic [3:0] trim;
    logic [7:0] count;
    logic       osc_en_hi, busy_hi, done_hi, locked_hi;
    logic [3:0] trim_hi;
    logic [7:0] count_hi;
    logic       osc_en_lo, busy_lo, done_lo, locked_lo;
    logic [3:0] trim_lo;
    logic [7:0] count_lo;
    logic       osc_en_sat, busy_sat, done_sat, locked_sat;
    logic [3:0] trim_sat;
    logic [7:0] count_sat;

    int n_cmp = 0;
    int n_err = 0;

    // Oscillator model: osc_per 0 = constant osc_const; trim_dep selects period 8 below trim 10, else 4
    int   tcnt = 0;
    int   osc_per = 4;
    logic osc_const = 1'b0;
    logic trim_dep = 1'b0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        int per;
        tcnt = tcnt + 1;
        per = trim_dep ? ((trim >= 4'd10) ? 4 : 8) : osc_per;
        osc_in = (per == 0) ? osc_const : ((tcnt % per) < (per / 2));
        osc_p8 = (tcnt % 8) < 4;
        osc_p2 = tcnt[0];
    end

    relax_osc_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .osc_in(osc_in),
        .target_lo(target_lo), .target_hi(target_hi),
        .osc_en(osc_en), .trim(trim), .count(count),
        .busy(busy), .done(done), .locked(locked)
    );

    relax_osc_ctrl #(.TRIM_INIT(15)) dut_hi (
        .clk(clk), .rst(rst), .start(start_x), .osc_in(osc_p8),
        .target_lo(target_lo), .target_hi(target_hi),
        .osc_en(osc_en_hi), .trim(trim_hi), .count(count_hi),
        .busy(busy_hi), .done(done_hi), .locked(locked_hi)
    );

    relax_osc_ctrl #(.TRIM_INIT(0)) dut_lo (
        .clk(clk), .rst(rst), .start(start_x), .osc_in(osc_p2),
        .target_lo(target_lo), .target_hi(target_hi),
        .osc_en(osc_en_lo), .trim(trim_lo), .count(count_lo),
        .busy(busy_lo), .done(done_lo), .locked(locked_lo)
    );

    relax_osc_ctrl #(.GATE_CYCLES(600)) dut_sat (
        .clk(clk), .rst(rst), .start(start_x), .osc_in(osc_p2),
        .target_lo(target_lo), .target_hi(target_hi),
        .osc_en(osc_en_sat), .trim(trim_sat), .count(count_sat),
        .busy(busy_sat), .done(done_sat), .locked(locked_sat)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offset 1 is the first cycle after the start edge; returns -1 on timeout
    task automatic wait_done(input int which, input int budget, output int off);
        logic d;
        off = 1;
        d = (which == 0) ? done : (which == 1) ? done_hi : done_sat;
        while (!d && off < budget) begin
            tick();
            off++;
            d = (which == 0) ? done : (which == 1) ? done_hi : done_sat;
        end
        if (!d) off = -1;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_osc_en"}, osc_en, 0);
        chk({tag, "_trim"},   trim,   8);
        chk({tag, "_count"},  count,  0);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_done"},   done,   0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        int off;
        int seen;

        // Reset with oscillator running
        rst = 1'b1;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        // Lock on the first pass: period 4 -> 4 edges in 16 cycles
        osc_per = 4;
        kick();
        chk("lock1_busy", busy, 1);
        chk("lock1_osc_en", osc_en, 1);
        wait_done(0, 200, off);
        chk("lock1_done_at", off, 22);
        chk("lock1_count", count, 4);
        chk("lock1_trim", trim, 8);
        chk("lock1_locked", locked, 1);
        tick();
        chk("lock1_done_pulse", done, 0);
        chk("lock1_busy_idle", busy, 0);
        tick();
        tick();
        chk("lock1_osc_en_hold", osc_en, 1);

        // Step up: counts 2,2,4 while trim walks 8->9->10
        trim_dep = 1'b1;
        kick();
        wait_done(0, 300, off);
        chk("stepup_done_at", off, 64);
        chk("stepup_trim", trim, 10);
        chk("stepup_count", count, 4);
        chk("stepup_locked", locked, 1);
        trim_dep = 1'b0;
        tick();

        // Iteration limit: constant count 2, trim ends at 12
        osc_per = 8;
        kick();
        wait_done(0, 300, off);
        chk("iter_done_at", off, 85);
        chk("iter_trim", trim, 12);
        chk("iter_count", count, 2);
        chk("iter_locked", locked, 0);
        chk("iter_osc_en", osc_en, 0);
        tick();
        chk("iter_done_pulse", done, 0);

        // Trim saturation at both ends, and edge-count saturation with a long gate
        start_x = 1'b1;
        tick();
        start_x = 1'b0;
        wait_done(1, 200, off);
        chk("sat_hi_done_at", off, 22);
        chk("sat_hi_trim", trim_hi, 15);
        chk("sat_hi_count", count_hi, 2);
        chk("sat_hi_locked", locked_hi, 0);
        chk("sat_hi_osc_en", osc_en_hi, 0);
        chk("sat_lo_done", done_lo, 1);
        chk("sat_lo_trim", trim_lo, 0);
        chk("sat_lo_count", count_lo, 8);
        chk("sat_lo_locked", locked_lo, 0);
        wait_done(2, 3000, off);
        chk("cnt_sat_done_at", off, 2400);
        chk("cnt_sat_count", count_sat, 255);
        chk("cnt_sat_trim", trim_sat, 4);
        tick();

        // start held high: one run, then one IDLE cycle, then a fresh run
        osc_per = 4;
        start = 1'b1;
        tick();
        wait_done(0, 200, off);
        chk("hold_done_at", off, 22);
        tick();
        chk("hold_idle_gap", busy, 0);
        tick();
        chk("hold_restart", busy, 1);
        chk("hold_restart_trim", trim, 8);
        start = 1'b0;
        wait_done(0, 200, off);
        chk("hold_second_done_at", off, 22);
        chk("hold_second_locked", locked, 1);
        tick();

        // Constant high oscillator yields no edges
        osc_per = 0;
        osc_const = 1'b1;
        kick();
        wait_done(0, 300, off);
        chk("const_done_at", off, 85);
        chk("const_count", count, 0);
        chk("const_trim", trim, 12);
        chk("const_locked", locked, 0);
        tick();

        // Reset during MEASURE aborts with no done pulse
        osc_per = 4;
        kick();
        for (int i = 0; i < 6; i++) tick();
        chk("abort_in_measure", busy, 1);
        rst = 1'b1;
        tick();
        chk_reset("abort");
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) seen = 1;
        end
        chk("abort_no_done", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
